// File: rtl/default_reset_mon.sv
// rtl/default_reset_mon.sv - observed reset pulse-width monitor
// Optional glitch filter: define DEFAULT_RESET_MON_GLITCH_FILTER_EN.
module default_reset_mon #(
    parameter int MIN_LOW_CYCLES = 2,
    parameter int MAX_LOW_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             RST_OBS,
    output logic             IN_RESET,
    output logic             PULSE_DONE,
    output logic [CNT_W-1:0] PULSE_LEN,
    output logic [7:0]       PULSE_COUNT,
    output logic             SHORT_ERR,
    output logic             LONG_ERR
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_HIGH,
        ST_LOW,
        ST_STUCK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STUCK_AT = CNT_W'(MAX_LOW_CYCLES + 1);
    localparam logic [CNT_W-1:0] MIN_LEN  = CNT_W'(MIN_LOW_CYCLES);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_inc;
    logic             obs_q;
    logic             filt;
    logic             done_d;
    logic             short_set;
    logic             long_set;

    // Single sampling stage for the observed reset; idles high (released)
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            obs_q <= 1'b1;
        end else begin
            obs_q <= RST_OBS;
        end
    end

`ifdef DEFAULT_RESET_MON_GLITCH_FILTER_EN
    logic obs_qq;
    logic filt_q;

    // Level only moves once two consecutive samples agree; otherwise hold it
    always_comb begin
        filt = filt_q;
        if (obs_q == obs_qq) begin
            filt = obs_q;
        end
    end

    // History for the two-sample agreement filter
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            obs_qq <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            obs_qq <= obs_q;
            filt_q <= filt;
        end
    end
`else
    assign filt = obs_q;
`endif

    assign count_inc = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;

    // State, counter and reported results; error flags are sticky until RESET
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            count_q     <= '0;
            PULSE_DONE  <= 1'b0;
            PULSE_LEN   <= '0;
            PULSE_COUNT <= '0;
            SHORT_ERR   <= 1'b0;
            LONG_ERR    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            PULSE_DONE <= done_d;
            if (done_d) begin
                PULSE_LEN   <= count_q;
                PULSE_COUNT <= PULSE_COUNT + 8'd1;
            end
            if (short_set) begin
                SHORT_ERR <= 1'b1;
            end
            if (long_set) begin
                LONG_ERR <= 1'b1;
            end
        end
    end

    // Next state, counter update and completion/error events
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        short_set = 1'b0;
        long_set  = 1'b0;
        case (state_q)
            ST_INIT, ST_HIGH: begin
                if (!filt) begin
                    state_d = ST_LOW;
                    count_d = CNT_W'(1);
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (!filt) begin
                    count_d = count_inc;
                    if (count_inc == STUCK_AT) begin
                        state_d  = ST_STUCK;
                        long_set = 1'b1;
                    end
                end else begin
                    state_d   = ST_HIGH;
                    done_d    = 1'b1;
                    short_set = (count_q < MIN_LEN);
                end
            end
            ST_STUCK: begin
                if (filt) begin
                    state_d = ST_HIGH;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Monitored reset is considered active while a low pulse is being timed
    always_comb begin
        IN_RESET = 1'b0;
        if (state_q == ST_LOW || state_q == ST_STUCK) begin
            IN_RESET = 1'b1;
        end
    end

endmodule

// File: tb/tb_default_reset_mon.sv
// tb/tb_default_reset_mon.sv - randomized bench for default_reset_mon
module tb_default_reset_mon;

    localparam int MIN_L = 2;
    localparam int MAX_L = 16;
    localparam int CNT_W = 8;

    logic             CLK_IN = 1'b0;
    logic             RESET;
    logic             RST_OBS;
    logic             IN_RESET;
    logic             PULSE_DONE;
    logic [CNT_W-1:0] PULSE_LEN;
    logic [7:0]       PULSE_COUNT;
    logic             SHORT_ERR;
    logic             LONG_ERR;

    int checks = 0;
    int errors = 0;

    // Reference: run length of low samples seen since the last release
    int   m_run;
    logic m_obs;
    logic m_done;
    int   m_len;
    int   m_cnt;
    logic m_short;
    logic m_long;

    always #5 CLK_IN = ~CLK_IN;

    default_reset_mon #(
        .MIN_LOW_CYCLES(MIN_L),
        .MAX_LOW_CYCLES(MAX_L),
        .CNT_W(CNT_W)
    ) dut (
        .CLK_IN(CLK_IN),
        .RESET(RESET),
        .RST_OBS(RST_OBS),
        .IN_RESET(IN_RESET),
        .PULSE_DONE(PULSE_DONE),
        .PULSE_LEN(PULSE_LEN),
        .PULSE_COUNT(PULSE_COUNT),
        .SHORT_ERR(SHORT_ERR),
        .LONG_ERR(LONG_ERR)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic obs);
        logic f;
        RESET   = rst;
        RST_OBS = obs;
        @(posedge CLK_IN);
        if (rst) begin
            m_run   = 0;
            m_obs   = 1'b1;
            m_done  = 1'b0;
            m_len   = 0;
            m_cnt   = 0;
            m_short = 1'b0;
            m_long  = 1'b0;
        end else begin
            f      = m_obs;
            m_done = 1'b0;
            if (!f) begin
                m_run++;
                if (m_run == MAX_L + 1) m_long = 1'b1;
            end else if (m_run > 0) begin
                m_done = 1'b1;
                m_len  = (m_run > MAX_L + 1) ? MAX_L + 1 : m_run;
                m_cnt  = (m_cnt + 1) % 256;
                if (m_run < MIN_L) m_short = 1'b1;
                m_run = 0;
            end
            m_obs = obs;
        end
        #1;
        check_val("in_reset",    32'(IN_RESET),    32'(m_run > 0));
        check_val("pulse_done",  32'(PULSE_DONE),  32'(m_done));
        check_val("pulse_len",   32'(PULSE_LEN),   32'(m_len));
        check_val("pulse_count", 32'(PULSE_COUNT), 32'(m_cnt));
        check_val("short_err",   32'(SHORT_ERR),   32'(m_short));
        check_val("long_err",    32'(LONG_ERR),    32'(m_long));
    endtask

    task automatic pulse(input int low_len, input int high_len);
        for (int i = 0; i < low_len; i++) step(1'b0, 1'b0);
        for (int i = 0; i < high_len; i++) step(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
    endtask

    initial begin
        RESET   = 1'b1;
        RST_OBS = 1'b1;
        do_reset();
        step(1'b0, 1'b1);
        check_val("reset_len", 32'(PULSE_LEN), 32'd0);

        // Nominal legal pulse
        pulse(2, 3);
        check_val("nom_len",   32'(PULSE_LEN),   32'd2);
        check_val("nom_cnt",   32'(PULSE_COUNT), 32'd1);
        check_val("nom_short", 32'(SHORT_ERR),   32'd0);

        // Single-cycle glitch is measured and flagged short
        pulse(1, 3);
        check_val("short_len", 32'(PULSE_LEN), 32'd1);
        check_val("short_err_set", 32'(SHORT_ERR), 32'd1);

        // Stuck low
        do_reset();
        pulse(20, 3);
        check_val("long_len", 32'(PULSE_LEN), 32'd17);
        check_val("long_err_set", 32'(LONG_ERR), 32'd1);

        // Exactly the maximum legal width
        do_reset();
        pulse(16, 3);
        check_val("max_len", 32'(PULSE_LEN), 32'd16);
        check_val("max_long", 32'(LONG_ERR), 32'd0);

        // Low from reset release
        step(1'b1, 1'b0);
        pulse(16, 3);

        // Reset mid-pulse abandons it
        do_reset();
        pulse(3, 0);
        step(1'b1, 1'b0);
        check_val("abandon_cnt", 32'(PULSE_COUNT), 32'd0);
        check_val("abandon_flags", 32'({SHORT_ERR, LONG_ERR}), 32'd0);
        pulse(2, 3);

        // Back-to-back pulses and counter wrap
        do_reset();
        for (int i = 0; i < 257; i++) pulse(2, 1);
        pulse(0, 2);
        check_val("wrap_cnt", 32'(PULSE_COUNT), 32'd1);
        check_val("wrap_short", 32'(SHORT_ERR), 32'd0);

        // Random pulses with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 30) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 4)));
            end
        end
        pulse(0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
